// File: rtl/qpsk_mod.sv
// QPSK modulator: 4-deep symbol FIFO, per-symbol sample counter, registered
// output. Ports: clk, rst (async, high), en, data/wr_sps (sps config),
// carrier_i/carrier_q (signed 8b), sym/sym_valid/sym_ready (symbol input),
// out (signed 10b), out_valid, underrun (1-cycle pulse).
// Macro QPSK_DIFF_ENC_EN: differential encoding (cur_sym = prev ^ popped).
module qpsk_mod (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] data,
   input  logic       wr_sps,
   input  logic [7:0] carrier_i,
   input  logic [7:0] carrier_q,
   input  logic [1:0] sym,
   input  logic       sym_valid,
   output logic       sym_ready,
   output logic [9:0] out,
   output logic       out_valid,
   output logic       underrun
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   logic [7:0] sps;
   logic [1:0] mem [4];
   logic [1:0] wptr;
   logic [1:0] rptr;
   logic [2:0] fcnt;
   logic       rdy_en;
   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   logic [0:0] state;
   logic [0:0] nxt;
   logic [7:0] scnt;
   logic [1:0] cur_sym;
   logic [1:0] head;
   logic [1:0] tx_sym;
   logic       unr_set;
   logic [9:0] ci_x;
   logic [9:0] cq_x;
   logic [9:0] ti;
   logic [9:0] tq;
   logic [9:0] sum;

   assign full      = (fcnt == 3'd4);
   assign empty     = (fcnt == 3'd0);
   assign sym_ready = rdy_en && !full;
   assign push      = sym_valid && sym_ready;
   assign head      = mem[rptr];

`ifdef QPSK_DIFF_ENC_EN
   logic [1:0] prev;

   assign tx_sym = prev ^ head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prev <= 2'b00;
      else if (pop)
         prev <= tx_sym;
   end
`else
   assign tx_sym = head;
`endif

   // sym_ready stays low while reset is held, rises at the first edge after
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rdy_en <= 1'b0;
      else
         rdy_en <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sps <= 8'd8;
      else if (wr_sps)
         sps <= data;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= sym;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= 2'd0;
         rptr <= 2'd0;
         fcnt <= 3'd0;
      end else begin
         if (push)
            wptr <= wptr + 2'd1;
         if (pop)
            rptr <= rptr + 2'd1;
         if (push && !pop)
            fcnt <= fcnt + 3'd1;
         else if (pop && !push)
            fcnt <= fcnt - 3'd1;
      end
   end

   always_comb begin
      nxt     = state;
      pop     = 1'b0;
      unr_set = 1'b0;
      unique case (state)
         IDLE: begin
            if (en && !empty) begin
               pop = 1'b1;
               nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!en) begin
               nxt = IDLE;
            end else if (scnt == 8'd0) begin
               if (!empty) begin
                  pop = 1'b1;
               end else begin
                  nxt     = IDLE;
                  unr_set = 1'b1;
               end
            end
         end
      endcase
   end

   // sps-1 wraps 0 to 255, giving 256 samples for a written 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         scnt     <= 8'd0;
         cur_sym  <= 2'b00;
         underrun <= 1'b0;
      end else begin
         state    <= nxt;
         underrun <= unr_set;
         if (pop) begin
            cur_sym <= tx_sym;
            scnt    <= sps - 8'd1;
         end else if (state == ACTIVE && !en) begin
            cur_sym <= 2'b00;
         end else if (state == ACTIVE && scnt != 8'd0) begin
            scnt <= scnt - 8'd1;
         end
      end
   end

   // bit 0 -> +carrier, bit 1 -> -carrier; 10 bits hold -256..+256
   assign ci_x = {{2{carrier_i[7]}}, carrier_i};
   assign cq_x = {{2{carrier_q[7]}}, carrier_q};
   assign ti   = cur_sym[1] ? (10'd0 - ci_x) : ci_x;
   assign tq   = cur_sym[0] ? (10'd0 - cq_x) : cq_x;
   assign sum  = ti + tq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= 10'd0;
         out_valid <= 1'b0;
      end else begin
         out       <= (state == ACTIVE) ? sum : 10'd0;
         out_valid <= (state == ACTIVE);
      end
   end

endmodule

// File: tb/tb_qpsk_mod.sv
// Directed testbench for qpsk_mod.
// Covers reset, mapping, FIFO flow control, sps handling, en drop, diff enc.
module tb_qpsk_mod;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] data = 8'd0;
   logic       wr_sps = 1'b0;
   logic [7:0] carrier_i = 8'd0;
   logic [7:0] carrier_q = 8'd0;
   logic [1:0] sym = 2'd0;
   logic       sym_valid = 1'b0;
   logic       sym_ready;
   logic [9:0] out;
   logic       out_valid;
   logic       underrun;

   int total = 0;
   int bad = 0;

   logic signed [9:0] vq[$];
   int ex[$];
   int nu;
   int gaps;
   bit tmo;

   qpsk_mod dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .data(data),
      .wr_sps(wr_sps),
      .carrier_i(carrier_i),
      .carrier_q(carrier_q),
      .sym(sym),
      .sym_valid(sym_valid),
      .sym_ready(sym_ready),
      .out(out),
      .out_valid(out_valid),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [1:0] s);
      @(posedge clk);
      #1;
      sym = s;
      sym_valid = 1'b1;
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
   endtask

   task automatic write_sps(input logic [7:0] v);
      @(posedge clk);
      #1;
      data = v;
      wr_sps = 1'b1;
      @(posedge clk);
      #1;
      wr_sps = 1'b0;
   endtask

   task automatic start_en;
      @(posedge clk);
      #1;
      en = 1'b1;
   endtask

   task automatic carriers(input int ci, input int cq);
      carrier_i = 8'(ci);
      carrier_q = 8'(cq);
   endtask

   task automatic expect_seg(input int v, input int n);
      for (int i = 0; i < n; i++)
         ex.push_back(v);
   endtask

   // Gathers valid samples; stops 2 cycles after the first underrun.
   task automatic collect(input int maxc, input int wr_at,
                          input logic [7:0] wr_val, input int drop_at);
      int post;
      bit seen;
      bit ended;
      vq.delete();
      nu = 0;
      gaps = 0;
      post = -1;
      seen = 0;
      ended = 0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            vq.push_back(out);
            if (ended)
               gaps++;
            seen = 1;
         end else if (seen) begin
            ended = 1;
         end
         if (underrun === 1'b1) begin
            nu++;
            if (post < 0)
               post = 2;
         end
         wr_sps = 1'b0;
         if (c == wr_at) begin
            data = wr_val;
            wr_sps = 1'b1;
         end
         if (c == drop_at)
            en = 1'b0;
         if (post == 0)
            break;
         if (post > 0)
            post--;
      end
      tmo = (post < 0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out !== 10'd0 || out_valid !== 1'b0 || underrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_out got out=%0d v=%b u=%b want 0 0 0",
                  out, out_valid, underrun);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (sym_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b want=1", sym_ready);
      end
      carriers(100, -50);
      push(2'b00);
      start_en;
      collect(30, -1, 8'd0, -1);
      en = 1'b0;
      ex.delete();
      expect_seg(50, 8);
      total++;
      if (vq.size() != 8 || nu != 1 || tmo || gaps != 0) begin
         bad++;
         $display("FAIL reset_sps8 got n=%0d u=%0d want n=8 u=1",
                  vq.size(), nu);
      end
      for (int i = 0; i < vq.size() && i < ex.size(); i++) begin
         total++;
         if (vq[i] !== 10'(ex[i])) begin
            bad++;
            $display("FAIL reset_val[%0d] got=%0d want=%0d", i, vq[i], ex[i]);
         end
      end
   endtask

   task automatic test_basic;
      write_sps(8'd4);
      carriers(100, -50);
      push(2'b00);
      push(2'b11);
      start_en;
      collect(30, -1, 8'd0, -1);
      en = 1'b0;
      ex.delete();
      expect_seg(50, 4);
      expect_seg(-50, 4);
      total++;
      if (vq.size() != 8 || nu != 1 || tmo || gaps != 0) begin
         bad++;
         $display("FAIL basic_len got n=%0d u=%0d g=%0d want n=8 u=1 g=0",
                  vq.size(), nu, gaps);
      end
      for (int i = 0; i < vq.size() && i < ex.size(); i++) begin
         total++;
         if (vq[i] !== 10'(ex[i])) begin
            bad++;
            $display("FAIL basic_val[%0d] got=%0d want=%0d", i, vq[i], ex[i]);
         end
      end
      total++;
      if (out_valid !== 1'b0 || underrun !== 1'b0) begin
         bad++;
         $display("FAIL basic_after got v=%b u=%b want 0 0",
                  out_valid, underrun);
      end
   endtask

   task automatic test_fifo_full;
      carriers(100, -50);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         sym = 2'(k);
         sym_valid = 1'b1;
         @(negedge clk);
         total++;
         if (sym_ready !== (k < 4)) begin
            bad++;
            $display("FAIL full_ready[%0d] got=%b want=%b",
                     k, sym_ready, (k < 4));
         end
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (sym_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_hold got=%b want=0", sym_ready);
      end
      sym_valid = 1'b0;
      en = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (sym_ready !== 1'b1) begin
         bad++;
         $display("FAIL full_pop got=%b want=1", sym_ready);
      end
      collect(40, -1, 8'd0, -1);
      en = 1'b0;
      ex.delete();
      expect_seg(50, 4);
      expect_seg(150, 4);
      expect_seg(-150, 4);
      expect_seg(-50, 4);
      total++;
      if (vq.size() != 16 || nu != 1 || tmo || gaps != 0) begin
         bad++;
         $display("FAIL full_len got n=%0d u=%0d want n=16 u=1",
                  vq.size(), nu);
      end
      for (int i = 0; i < vq.size() && i < ex.size(); i += 4) begin
         total++;
         if (vq[i] !== 10'(ex[i])) begin
            bad++;
            $display("FAIL full_val[%0d] got=%0d want=%0d", i, vq[i], ex[i]);
         end
      end
   endtask

   task automatic test_extremes;
      carriers(-128, -128);
      push(2'b11);
      push(2'b00);
      start_en;
      collect(30, -1, 8'd0, -1);
      en = 1'b0;
      ex.delete();
      expect_seg(256, 4);
      expect_seg(-256, 4);
      total++;
      if (vq.size() != 8 || nu != 1 || tmo) begin
         bad++;
         $display("FAIL ext_len got n=%0d u=%0d want n=8 u=1", vq.size(), nu);
      end
      for (int i = 0; i < vq.size() && i < ex.size(); i += 3) begin
         total++;
         if (vq[i] !== 10'(ex[i])) begin
            bad++;
            $display("FAIL ext_val[%0d] got=%0d want=%0d", i, vq[i], ex[i]);
         end
      end
   endtask

   task automatic test_sps;
      int nbad;
      carriers(100, -50);
      write_sps(8'd0);
      push(2'b00);
      start_en;
      collect(300, -1, 8'd0, -1);
      en = 1'b0;
      nbad = 0;
      foreach (vq[i])
         if (vq[i] !== 10'sd50)
            nbad++;
      total++;
      if (vq.size() != 256 || nu != 1 || tmo || nbad != 0) begin
         bad++;
         $display("FAIL sps0 got n=%0d u=%0d badv=%0d want n=256 u=1 badv=0",
                  vq.size(), nu, nbad);
      end
      write_sps(8'd4);
      push(2'b00);
      push(2'b11);
      start_en;
      collect(30, 1, 8'd2, -1);
      en = 1'b0;
      ex.delete();
      expect_seg(50, 4);
      expect_seg(-50, 2);
      total++;
      if (vq.size() != 6 || nu != 1 || tmo || gaps != 0) begin
         bad++;
         $display("FAIL sps_mid_len got n=%0d u=%0d want n=6 u=1",
                  vq.size(), nu);
      end
      for (int i = 0; i < vq.size() && i < ex.size(); i++) begin
         total++;
         if (vq[i] !== 10'(ex[i])) begin
            bad++;
            $display("FAIL sps_mid[%0d] got=%0d want=%0d", i, vq[i], ex[i]);
         end
      end
      write_sps(8'd4);
   endtask

   task automatic test_en_drop;
      carriers(100, -50);
      push(2'b00);
      push(2'b01);
      push(2'b10);
      start_en;
      collect(8, -1, 8'd0, 2);
      total++;
      if (vq.size() != 2 || nu != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drop_stop got n=%0d u=%0d v=%b want n=2 u=0 v=0",
                  vq.size(), nu, out_valid);
      end
      start_en;
      collect(40, -1, 8'd0, -1);
      en = 1'b0;
      ex.delete();
      expect_seg(150, 4);
      expect_seg(-150, 4);
      total++;
      if (vq.size() != 8 || nu != 1 || tmo) begin
         bad++;
         $display("FAIL drop_resume got n=%0d u=%0d want n=8 u=1",
                  vq.size(), nu);
      end
      for (int i = 0; i < vq.size() && i < ex.size(); i += 2) begin
         total++;
         if (vq[i] !== 10'(ex[i])) begin
            bad++;
            $display("FAIL drop_val[%0d] got=%0d want=%0d", i, vq[i], ex[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      carriers(100, -50);
      push(2'b00);
      push(2'b11);
      start_en;
      repeat (3) @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rmid_pre got v=%b want=1", out_valid);
      end
      rst = 1'b1;
      #1;
      total++;
      if (out !== 10'd0 || out_valid !== 1'b0 || underrun !== 1'b0) begin
         bad++;
         $display("FAIL rmid_async got out=%0d v=%b u=%b want 0 0 0",
                  out, out_valid, underrun);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      collect(14, -1, 8'd0, -1);
      en = 1'b0;
      total++;
      if (vq.size() != 0 || nu != 0) begin
         bad++;
         $display("FAIL rmid_lost got n=%0d u=%0d want n=0 u=0",
                  vq.size(), nu);
      end
   endtask

   task automatic test_symbol_map;
      carriers(100, -50);
      write_sps(8'd4);
      push(2'b01);
      push(2'b01);
      push(2'b10);
      start_en;
      collect(40, -1, 8'd0, -1);
      en = 1'b0;
      ex.delete();
      expect_seg(150, 4);
`ifdef QPSK_DIFF_ENC_EN
      expect_seg(50, 4);
`else
      expect_seg(150, 4);
`endif
      expect_seg(-150, 4);
      total++;
      if (vq.size() != 12 || nu != 1 || tmo) begin
         bad++;
         $display("FAIL map_len got n=%0d u=%0d want n=12 u=1", vq.size(), nu);
      end
      for (int i = 0; i < vq.size() && i < ex.size(); i += 4) begin
         total++;
         if (vq[i] !== 10'(ex[i])) begin
            bad++;
            $display("FAIL map_val[%0d] got=%0d want=%0d", i, vq[i], ex[i]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_fifo_full;
      test_extremes;
      test_sps;
      test_en_drop;
      test_reset_mid;
      test_symbol_map;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
